// File: rtl/bullet_pkg.sv
// bullet_pkg: shared coordinate types, slot states and the hit-box test
package bullet_pkg;
  typedef logic [9:0] coord_t;
  typedef enum logic {IDLE, FLYING} slot_state_e;
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;
  function automatic logic in_box(coord_t px, coord_t py, coord_t cx, coord_t cy, coord_t size);
    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    x_lo = cx >= size ? {1'b0, cx - size} : 11'd0;
    y_lo = cy >= size ? {1'b0, cy - size} : 11'd0;
    x_hi = {1'b0, cx} + {1'b0, size};
    y_hi = {1'b0, cy} + {1'b0, size};
    return {1'b0, px} >= x_lo && {1'b0, px} <= x_hi && {1'b0, py} >= y_lo && {1'b0, py} <= y_hi;
  endfunction
endpackage

// File: rtl/bullet_slot.sv
// bullet_slot: one projectile slot, launches on request and retires at the top edge or on a hit
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int Y_STEP = 5,
  parameter int PARK_X = 650,
  parameter int PARK_Y = 500
) (
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   launch,
  input  coord_t launch_x,
  input  coord_t launch_y,
  input  logic   hit,
  output coord_t x,
  output coord_t y,
  output logic   active
);
  localparam coord_t STEP = coord_t'(Y_STEP);
  localparam coord_t PX = coord_t'(PARK_X);
  localparam coord_t PY = coord_t'(PARK_Y);
  slot_state_e state, state_next;
  coord_t x_next, y_next;
  assign active = state == FLYING;
  // slot state and position register
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
      x <= PX;
      y <= PY;
    end else begin
      state <= state_next;
      x <= x_next;
      y <= y_next;
    end
  end
  // launch from idle; a flying bullet retires at the top edge or on a hit, else rises
  always_comb begin
    state_next = state;
    x_next = x;
    y_next = y;
    if (state == IDLE) begin
      if (launch) begin
        state_next = FLYING;
        x_next = launch_x;
        y_next = launch_y;
      end
    end else if (y < STEP || hit) begin
      state_next = IDLE;
      x_next = PX;
      y_next = PY;
    end else begin
      y_next = y - STEP;
    end
  end
endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player projectile engine with cooldown and per-ship hit pulses (optional BULLET_POOL_SCORE_EN adds hit_count)
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int NUM_SHIPS = 10,
  parameter int Y_STEP = 5,
  parameter int COOLDOWN = 8,
  parameter int PARK_X = 650,
  parameter int PARK_Y = 500,
  parameter int BULLET_SIZE = 2
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    fire,
  input  logic [9:0]              ShooterX,
  input  logic [9:0]              ShooterY,
  input  logic [NUM_SHIPS*10-1:0] ShipX,
  input  logic [NUM_SHIPS*10-1:0] ShipY,
  input  logic [NUM_SHIPS*10-1:0] ShipSize,
  input  logic [NUM_SHIPS-1:0]    ship_alive,
  output logic [NUM_BULLETS*10-1:0] BulletX,
  output logic [NUM_BULLETS*10-1:0] BulletY,
  output logic [9:0]              BulletS,
  output logic [NUM_BULLETS-1:0]  bullet_active,
  output logic                    loaded,
  output logic [NUM_SHIPS-1:0]    ShipHit
`ifdef BULLET_POOL_SCORE_EN
  ,
  output logic [15:0]             hit_count
`endif
);
  localparam int CW = $clog2(COOLDOWN + 2);
  localparam coord_t STEP = coord_t'(Y_STEP);
  logic [CW-1:0] cooldown;
  logic [NUM_BULLETS-1:0] launch, slot_hit;
  logic [NUM_SHIPS-1:0] hit_next;
  logic [NUM_SHIPS-1:0] first_hit [NUM_BULLETS];
  assign BulletS = 10'(BULLET_SIZE);
  assign loaded = (|(~bullet_active)) && cooldown == '0;
  // lowest-index idle slot takes the shot when a fire is accepted
  always_comb begin
    launch = '0;
    for (int b = NUM_BULLETS - 1; b >= 0; b--)
      if (fire && loaded && !bullet_active[b]) begin
        launch = '0;
        launch[b] = 1'b1;
      end
  end
  // each flying bullet claims the lowest-index alive ship it overlaps
  always_comb begin
    hit_next = '0;
    slot_hit = '0;
    first_hit = '{default: '0};
    for (int b = 0; b < NUM_BULLETS; b++) begin
      for (int s = NUM_SHIPS - 1; s >= 0; s--)
        if (bullet_active[b] && BulletY[b*10+:10] >= STEP && ship_alive[s] &&
            in_box(BulletX[b*10+:10], BulletY[b*10+:10], ShipX[s*10+:10], ShipY[s*10+:10], ShipSize[s*10+:10])) begin
          first_hit[b] = '0;
          first_hit[b][s] = 1'b1;
        end
      hit_next = hit_next | first_hit[b];
      slot_hit[b] = |first_hit[b];
    end
  end
  // fire cooldown counter and registered one-frame hit pulses
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      cooldown <= '0;
      ShipHit <= '0;
    end else begin
      cooldown <= |launch ? CW'(COOLDOWN) : cooldown == '0 ? '0 : cooldown - 1'b1;
      ShipHit <= hit_next;
    end
  end
`ifdef BULLET_POOL_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, hit_count} + 17'($countones(hit_next));
  // saturating score counter, advanced together with ShipHit
  always_ff @(posedge frame_clk) begin
    if (Reset) hit_count <= '0;
    else hit_count <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`endif
  for (genvar b = 0; b < NUM_BULLETS; b++) begin : g_slot
    bullet_slot #(.Y_STEP(Y_STEP), .PARK_X(PARK_X), .PARK_Y(PARK_Y)) u_slot (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .launch(launch[b]),
      .launch_x(ShooterX),
      .launch_y(ShooterY),
      .hit(slot_hit[b]),
      .x(BulletX[b*10+:10]),
      .y(BulletY[b*10+:10]),
      .active(bullet_active[b])
    );
  end
endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed checks of launch, flight, cooldown, hits and reset
module tb_bullet_pool;
  localparam int NB = 4;
  localparam int NS = 10;
  logic frame_clk, Reset, fire, loaded;
  logic [9:0] ShooterX, ShooterY, BulletS;
  logic [NS*10-1:0] ShipX, ShipY, ShipSize;
  logic [NS-1:0] ship_alive, ShipHit;
  logic [NB*10-1:0] BulletX, BulletY;
  logic [NB-1:0] bullet_active;
`ifdef BULLET_POOL_SCORE_EN
  logic [15:0] hit_count;
`endif
  int checks = 0;
  int errors = 0;

  bullet_pool #(.NUM_BULLETS(NB), .NUM_SHIPS(NS)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .fire(fire),
    .ShooterX(ShooterX), .ShooterY(ShooterY),
    .ShipX(ShipX), .ShipY(ShipY), .ShipSize(ShipSize), .ship_alive(ship_alive),
    .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS),
    .bullet_active(bullet_active), .loaded(loaded), .ShipHit(ShipHit)
`ifdef BULLET_POOL_SCORE_EN
    , .hit_count(hit_count)
`endif
  );

  initial frame_clk = 0;
  always #5 frame_clk = ~frame_clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic set_ship(input int s, input int x, input int y, input int sz);
    ShipX[s*10+:10] = 10'(x);
    ShipY[s*10+:10] = 10'(y);
    ShipSize[s*10+:10] = 10'(sz);
  endtask

  task automatic do_reset();
    fire = 0;
    ship_alive = '0;
    ShipX = '0;
    ShipY = '0;
    ShipSize = '0;
    Reset = 1;
    step();
    Reset = 0;
  endtask

  task automatic test_reset();
    step();
    Reset = 0;
    checks++; if (bullet_active !== 4'b0000) begin errors++; $display("FAIL reset_active got %b want 0000", bullet_active); end
    checks++; if (ShipHit !== 10'b0) begin errors++; $display("FAIL reset_shiphit got %b want 0", ShipHit); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL reset_loaded got %b want 1", loaded); end
    checks++; if (BulletX !== {4{10'd650}}) begin errors++; $display("FAIL reset_x got %h want park 650", BulletX); end
    checks++; if (BulletY !== {4{10'd500}}) begin errors++; $display("FAIL reset_y got %h want park 500", BulletY); end
    checks++; if (BulletS !== 10'd2) begin errors++; $display("FAIL bullet_size got %0d want 2", BulletS); end
  endtask

  task automatic test_fly();
    do_reset();
    ShooterX = 320;
    ShooterY = 440;
    fire = 1;
    step();
    fire = 0;
    checks++; if (bullet_active !== 4'b0001) begin errors++; $display("FAIL fly_launch_active got %b want 0001", bullet_active); end
    checks++; if (BulletX[9:0] !== 10'd320) begin errors++; $display("FAIL fly_launch_x got %0d want 320", BulletX[9:0]); end
    checks++; if (BulletY[9:0] !== 10'd440) begin errors++; $display("FAIL fly_launch_y got %0d want 440", BulletY[9:0]); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL fly_loaded_cooldown got %b want 0", loaded); end
    step();
    checks++; if (BulletY[9:0] !== 10'd435) begin errors++; $display("FAIL fly_rise got %0d want 435", BulletY[9:0]); end
    step(87);
    checks++; if (BulletY[9:0] !== 10'd0) begin errors++; $display("FAIL fly_top_y got %0d want 0", BulletY[9:0]); end
    checks++; if (bullet_active !== 4'b0001) begin errors++; $display("FAIL fly_top_active got %b want 0001", bullet_active); end
    step();
    checks++; if (bullet_active !== 4'b0000) begin errors++; $display("FAIL fly_retire_active got %b want 0000", bullet_active); end
    checks++; if (BulletX[9:0] !== 10'd650 || BulletY[9:0] !== 10'd500) begin errors++; $display("FAIL fly_park got %0d,%0d want 650,500", BulletX[9:0], BulletY[9:0]); end
    checks++; if (ShipHit !== 10'b0) begin errors++; $display("FAIL fly_no_hit got %b want 0", ShipHit); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL fly_reloaded got %b want 1", loaded); end
  endtask

  task automatic test_cooldown();
    logic [3:0] exp_act;
    logic exp_ld;
    int n;
    do_reset();
    ShooterX = 200;
    ShooterY = 440;
    fire = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      n = i / 9 + 1;
      if (n > 4) n = 4;
      exp_act = 4'((1 << n) - 1);
      exp_ld = (i < 27) && (i % 9 == 8);
      checks++; if (bullet_active !== exp_act) begin errors++; $display("FAIL cooldown_active frame %0d got %b want %b", i, bullet_active, exp_act); end
      checks++; if (loaded !== exp_ld) begin errors++; $display("FAIL cooldown_loaded frame %0d got %b want %b", i, loaded, exp_ld); end
    end
    fire = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ShooterX = 50;
    ShooterY = 400;
    fire = 1;
    step(19);
    fire = 0;
    checks++; if (bullet_active !== 4'b0111) begin errors++; $display("FAIL mid_three_flying got %b want 0111", bullet_active); end
    Reset = 1;
    step();
    Reset = 0;
    checks++; if (bullet_active !== 4'b0000) begin errors++; $display("FAIL mid_reset_active got %b want 0000", bullet_active); end
    checks++; if (ShipHit !== 10'b0) begin errors++; $display("FAIL mid_reset_shiphit got %b want 0", ShipHit); end
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL mid_reset_loaded got %b want 1", loaded); end
    checks++; if (BulletY !== {4{10'd500}}) begin errors++; $display("FAIL mid_reset_park got %h want park 500", BulletY); end
`ifdef BULLET_POOL_SCORE_EN
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL mid_reset_score got %0d want 0", hit_count); end
`endif
  endtask

  task automatic test_hit();
    do_reset();
    set_ship(2, 320, 200, 10);
    ship_alive = 10'b0000000100;
    ShooterX = 320;
    ShooterY = 440;
    fire = 1;
    step();
    fire = 0;
    step(46);
    checks++; if (BulletY[9:0] !== 10'd210) begin errors++; $display("FAIL hit_approach_y got %0d want 210", BulletY[9:0]); end
    checks++; if (ShipHit !== 10'b0) begin errors++; $display("FAIL hit_early got %b want 0", ShipHit); end
    step();
    checks++; if (ShipHit !== 10'b0000000100) begin errors++; $display("FAIL hit_pulse got %b want 0000000100", ShipHit); end
    checks++; if (bullet_active !== 4'b0000) begin errors++; $display("FAIL hit_retire got %b want 0000", bullet_active); end
    checks++; if (BulletY[9:0] !== 10'd500) begin errors++; $display("FAIL hit_park got %0d want 500", BulletY[9:0]); end
`ifdef BULLET_POOL_SCORE_EN
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL hit_score got %0d want 1", hit_count); end
`endif
    step();
    checks++; if (ShipHit !== 10'b0) begin errors++; $display("FAIL hit_one_frame got %b want 0", ShipHit); end
  endtask

  task automatic test_overlap();
    do_reset();
    set_ship(0, 100, 100, 8);
    set_ship(1, 100, 100, 8);
    ship_alive = 10'b0000000011;
    ShooterX = 100;
    ShooterY = 110;
    fire = 1;
    step();
    fire = 0;
    step();
    checks++; if (BulletY[9:0] !== 10'd105 || ShipHit !== 10'b0) begin errors++; $display("FAIL overlap_approach got y=%0d hit=%b want y=105 hit=0", BulletY[9:0], ShipHit); end
    step();
    checks++; if (ShipHit !== 10'b0000000001) begin errors++; $display("FAIL overlap_priority got %b want 0000000001", ShipHit); end
    checks++; if (bullet_active !== 4'b0000) begin errors++; $display("FAIL overlap_retire got %b want 0000", bullet_active); end
  endtask

  task automatic test_underflow();
    do_reset();
    set_ship(0, 3, 100, 10);
    ship_alive = 10'b0000000001;
    ShooterX = 0;
    ShooterY = 105;
    fire = 1;
    step();
    fire = 0;
    step();
    checks++; if (ShipHit !== 10'b0000000001) begin errors++; $display("FAIL underflow_hit got %b want 0000000001", ShipHit); end
    checks++; if (bullet_active !== 4'b0000) begin errors++; $display("FAIL underflow_retire got %b want 0000", bullet_active); end
  endtask

  initial begin
    Reset = 1;
    fire = 0;
    ShooterX = 0;
    ShooterY = 0;
    ShipX = '0;
    ShipY = '0;
    ShipSize = '0;
    ship_alive = '0;
    test_reset();
    test_fly();
    test_cooldown();
    test_reset_mid();
    test_hit();
    test_overlap();
    test_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
